// File: rtl/ftdi_pkg.sv
// Shared FSM encodings and default sizing for the FT245 responder.
package ftdi_pkg;

    localparam int DEFAULT_DEPTH     = 16;
    localparam int DEFAULT_PRECHARGE = 2;
    localparam int PRE_W             = 8;

    typedef enum logic [1:0] {
        RD_IDLE      = 2'd0,
        RD_DRIVE     = 2'd1,
        RD_PRECHARGE = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE      = 2'd0,
        WR_LOW       = 2'd1,
        WR_PRECHARGE = 2'd2
    } wr_state_t;

    // Down-counter reload value; the counter spends one cycle per count including zero.
    function automatic logic [PRE_W-1:0] precharge_load(input int cycles);
        return (cycles > 1) ? PRE_W'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers; also exposes next-cycle full/empty so the
// owner can register its flags without an extra cycle of lag.
module byte_fifo
    import ftdi_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       full_next,
    output logic       empty_next
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr_next;
    logic [AW:0] rd_ptr_next;
    logic [7:0]  mem [DEPTH];
    logic        push_en;
    logic        pop_en;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    assign wr_ptr_next = wr_ptr + (AW+1)'(push_en);
    assign rd_ptr_next = rd_ptr + (AW+1)'(pop_en);

    assign full_next  = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                        (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    assign empty_next = (wr_ptr_next == rd_ptr_next);

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
        end
    end

    always_ff @(posedge clock_in) begin
        if (push_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ft245_responder.sv
// FT245-style slave: answers host RD#/WR# strobes on io_245 from two byte FIFOs.
// state        | meaning
// RD_IDLE      | waiting for a host RD# fall
// RD_DRIVE     | host read in progress, FIFO head on io_245
// RD_PRECHARGE | RXF# held high after the read strobe
// WR_IDLE      | waiting for a host WR# fall
// WR_LOW       | byte captured, waiting for WR# to return high
// WR_PRECHARGE | TXE# held high after the write strobe
module ft245_responder
    import ftdi_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int PRECHARGE = DEFAULT_PRECHARGE
) (
    input  logic       clock_in,
    input  logic       reset,
    inout  wire  [7:0] io_245,
    output logic       rx_available,
    input  logic       rx_ftdi_flag,
    output logic       tx_available,
    input  logic       tx_ftdi_flag,
    input  logic [7:0] pc_tx_data,
    input  logic       pc_tx_valid,
    output logic       pc_tx_ready,
    output logic [7:0] pc_rx_data,
    output logic       pc_rx_valid,
    input  logic       pc_rx_ready,
    output logic       proto_err
);

    localparam logic [PRE_W-1:0] PRE_LOAD = precharge_load(PRECHARGE);

    logic [1:0] rd_sync;
    logic [1:0] wr_sync;
    logic [7:0] data_meta;
    logic [7:0] data_s;
    logic [1:0] sync_fill;
    logic       rd_s;
    logic       wr_s;
    logic       rd_prev;
    logic       wr_prev;
    logic       rd_armed;
    logic       wr_armed;
    logic       rd_fall;
    logic       rd_rise;
    logic       wr_fall;
    logic       wr_rise;

    rd_state_t        rd_state;
    rd_state_t        rd_next;
    wr_state_t        wr_state;
    wr_state_t        wr_next;
    logic [PRE_W-1:0] rd_cnt;
    logic [PRE_W-1:0] wr_cnt;

    logic       tx_push;
    logic       tx_pop;
    logic [7:0] tx_head;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_full_next;
    logic       tx_empty_next;
    logic       rx_push;
    logic       rx_pop;
    logic [7:0] rx_head;
    logic       rx_full;
    logic       rx_empty;
    logic       rx_full_next;
    logic       rx_empty_next;
    logic       rd_err;
    logic       wr_err;
    logic       bus_drive;

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            rd_sync   <= 2'b11;
            wr_sync   <= 2'b11;
            data_meta <= 8'hFF;
            data_s    <= 8'hFF;
            sync_fill <= 2'b00;
        end else begin
            rd_sync   <= {rd_sync[0], rx_ftdi_flag};
            wr_sync   <= {wr_sync[0], tx_ftdi_flag};
            data_meta <= io_245;
            data_s    <= data_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign rd_s = rd_sync[1];
    assign wr_s = wr_sync[1];

    // A strobe only counts as falling once it has been seen high after reset,
    // so a strobe held low through reset release is not mistaken for a new one.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            rd_prev  <= 1'b1;
            wr_prev  <= 1'b1;
            rd_armed <= 1'b0;
            wr_armed <= 1'b0;
        end else begin
            rd_prev <= rd_s;
            wr_prev <= wr_s;
            if (sync_fill[1] && rd_s) rd_armed <= 1'b1;
            if (sync_fill[1] && wr_s) wr_armed <= 1'b1;
        end
    end

    assign rd_fall = rd_armed && rd_prev && !rd_s;
    assign rd_rise = !rd_prev && rd_s;
    assign wr_fall = wr_armed && wr_prev && !wr_s;
    assign wr_rise = !wr_prev && wr_s;

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            rd_state <= RD_IDLE;
            rd_cnt   <= '0;
        end else begin
            rd_state <= rd_next;
            if (rd_state != RD_PRECHARGE) rd_cnt <= PRE_LOAD;
            else if (rd_cnt != '0)        rd_cnt <= rd_cnt - PRE_W'(1);
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE:      if (rd_fall && !rx_available) rd_next = RD_DRIVE;
            RD_DRIVE:     if (rd_rise) rd_next = RD_PRECHARGE;
            RD_PRECHARGE: if (rd_cnt == '0) rd_next = RD_IDLE;
            default:      rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        tx_pop = 1'b0;
        rd_err = 1'b0;
        if ((rd_state == RD_DRIVE) && rd_rise) tx_pop = !tx_empty;
        if (rd_fall && rx_available) rd_err = 1'b1;
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            wr_state <= WR_IDLE;
            wr_cnt   <= '0;
        end else begin
            wr_state <= wr_next;
            if (wr_state != WR_PRECHARGE) wr_cnt <= PRE_LOAD;
            else if (wr_cnt != '0)        wr_cnt <= wr_cnt - PRE_W'(1);
        end
    end

    // A write overlapping an active read is dropped; the read keeps the bus.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE:      if (wr_fall && !tx_available && rd_s) wr_next = WR_LOW;
            WR_LOW:       if (wr_rise) wr_next = WR_PRECHARGE;
            WR_PRECHARGE: if (wr_cnt == '0) wr_next = WR_IDLE;
            default:      wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rx_push = 1'b0;
        wr_err  = 1'b0;
        if ((wr_state == WR_IDLE) && wr_fall && !tx_available && rd_s) rx_push = !rx_full;
        if ((wr_fall && tx_available) || (!rd_s && !wr_s)) wr_err = 1'b1;
    end

    assign tx_push = pc_tx_valid && pc_tx_ready && !tx_full;
    assign rx_pop  = pc_rx_valid && pc_rx_ready && !rx_empty;

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clock_in   (clock_in),
        .reset      (reset),
        .push       (tx_push),
        .push_data  (pc_tx_data),
        .pop        (tx_pop),
        .head       (tx_head),
        .full       (tx_full),
        .empty      (tx_empty),
        .full_next  (tx_full_next),
        .empty_next (tx_empty_next)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clock_in   (clock_in),
        .reset      (reset),
        .push       (rx_push),
        .push_data  (data_s),
        .pop        (rx_pop),
        .head       (rx_head),
        .full       (rx_full),
        .empty      (rx_empty),
        .full_next  (rx_full_next),
        .empty_next (rx_empty_next)
    );

    // Flags are registered from next-cycle state so they track the FIFOs without lag.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            rx_available <= 1'b1;
            tx_available <= 1'b1;
            pc_tx_ready  <= 1'b0;
            pc_rx_valid  <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            rx_available <= !(((rd_next == RD_IDLE) || (rd_next == RD_DRIVE)) && !tx_empty_next);
            tx_available <= rx_full_next || (wr_next != WR_IDLE);
            pc_tx_ready  <= !tx_full_next;
            pc_rx_valid  <= !rx_empty_next;
            proto_err    <= proto_err || rd_err || wr_err;
        end
    end

    assign bus_drive  = !rx_ftdi_flag && (!rx_available || (rd_state == RD_DRIVE));
    assign io_245     = bus_drive ? tx_head : 8'hzz;
    assign pc_rx_data = pc_rx_valid ? rx_head : 8'h00;

endmodule

// File: tb/tb_ft245_responder.sv
// Directed bench for ft245_responder; io_245 carries a pull-up, so a released bus reads 8'hFF.
module tb_ft245_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] pc_tx_data;
    logic       pc_tx_valid;
    logic       pc_tx_ready;
    logic [7:0] pc_rx_data;
    logic       pc_rx_valid;
    logic       pc_rx_ready;
    logic       rx_available;
    logic       tx_available;
    logic       proto_err;
    logic [7:0] host_data;
    logic       host_oe;
    logic [7:0] d0;
    logic [7:0] d1;
    wire  [7:0] bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign bus = host_oe ? host_data : 8'hzz;
    pullup (bus);

    ft245_responder dut (
        .clock_in     (clk),
        .reset        (rst_n),
        .io_245       (bus),
        .rx_available (rx_available),
        .rx_ftdi_flag (rd_n),
        .tx_available (tx_available),
        .tx_ftdi_flag (wr_n),
        .pc_tx_data   (pc_tx_data),
        .pc_tx_valid  (pc_tx_valid),
        .pc_tx_ready  (pc_tx_ready),
        .pc_rx_data   (pc_rx_data),
        .pc_rx_valid  (pc_rx_valid),
        .pc_rx_ready  (pc_rx_ready),
        .proto_err    (proto_err)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int k);
        return 8'(k * 37 + 5);
    endfunction

    task automatic pc_push(input logic [7:0] d);
        pc_tx_data  = d;
        pc_tx_valid = 1'b1;
        tick(1);
        pc_tx_valid = 1'b0;
    endtask

    // RD# low for three clocks; samples the bus just after the fall and just before the rise.
    task automatic host_read(output logic [7:0] first, output logic [7:0] last, input int settle);
        rd_n = 1'b0;
        #1;
        first = bus;
        tick(3);
        last = bus;
        rd_n = 1'b1;
        if (settle > 0) tick(settle);
    endtask

    // One-clock WR# pulse with data held until the synchronizer has taken it.
    task automatic host_write(input logic [7:0] d);
        host_data = d;
        host_oe   = 1'b1;
        wr_n      = 1'b0;
        tick(1);
        wr_n = 1'b1;
        tick(2);
        host_oe = 1'b0;
        tick(3);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        rd_n        = 1'b1;
        wr_n        = 1'b1;
        pc_tx_data  = 8'h00;
        pc_tx_valid = 1'b0;
        pc_rx_ready = 1'b0;
        host_data   = 8'h00;
        host_oe     = 1'b0;
        tick(2);

        check1("rst_rxf", rx_available, 1'b1);
        check1("rst_txe", tx_available, 1'b1);
        check1("rst_tx_ready", pc_tx_ready, 1'b0);
        check1("rst_rx_valid", pc_rx_valid, 1'b0);
        check8("rst_rx_data", pc_rx_data, 8'h00);
        check1("rst_err", proto_err, 1'b0);
        check8("rst_bus", bus, 8'hFF);

        rst_n = 1'b1;
        tick(1);
        check1("tx_ready_first_clk", pc_tx_ready, 1'b1);
        check1("txe_low_after_rst", tx_available, 1'b0);
        tick(3);

        // single byte toward the host
        check1("rxf_idle_empty", rx_available, 1'b1);
        pc_push(8'hA5);
        check1("rxf_push_latency", rx_available, 1'b0);
        host_read(d0, d1, 0);
        check8("read_a5_first", d0, 8'hA5);
        check8("read_a5_last", d1, 8'hA5);
        tick(3);
        check1("rxf_after_pop", rx_available, 1'b1);
        check8("bus_released", bus, 8'hFF);
        tick(2);
        check1("rxf_empty_after_pre", rx_available, 1'b1);

        // precharge spacing with a second byte waiting
        pc_push(8'h11);
        pc_push(8'h22);
        host_read(d0, d1, 0);
        check8("read_11", d0, 8'h11);
        tick(3);
        check1("rd_pre_cycle1", rx_available, 1'b1);
        tick(1);
        check1("rd_pre_cycle2", rx_available, 1'b1);
        tick(1);
        check1("rd_pre_done", rx_available, 1'b0);
        host_read(d0, d1, 5);
        check8("read_22", d0, 8'h22);
        check1("rxf_empty_again", rx_available, 1'b1);

        // one-clock write pulse
        host_data = 8'h3C;
        host_oe   = 1'b1;
        wr_n      = 1'b0;
        tick(1);
        wr_n = 1'b1;
        tick(2);
        host_oe = 1'b0;
        check1("wr_rx_valid", pc_rx_valid, 1'b1);
        check8("wr_rx_data", pc_rx_data, 8'h3C);
        check1("wr_txe_low_phase", tx_available, 1'b1);
        tick(2);
        check1("wr_txe_precharge", tx_available, 1'b1);
        tick(1);
        check1("wr_txe_idle", tx_available, 1'b0);
        pc_rx_ready = 1'b1;
        tick(1);
        pc_rx_ready = 1'b0;
        check1("wr_single_byte", pc_rx_valid, 1'b0);

        // fill from-host FIFO, overflow attempt, drain in order
        for (int i = 0; i < 16; i++) host_write(8'(i));
        check1("full_txe_high", tx_available, 1'b1);
        tick(4);
        check1("full_txe_stays", tx_available, 1'b1);
        check1("full_no_err_yet", proto_err, 1'b0);
        host_write(8'hEE);
        check1("overflow_err", proto_err, 1'b1);
        pc_rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check8("drain_order", pc_rx_data, 8'(i));
            tick(1);
        end
        pc_rx_ready = 1'b0;
        check1("drain_empty", pc_rx_valid, 1'b0);
        check1("drain_txe_low", tx_available, 1'b0);

        // continuous traffic across pointer wrap
        reset_pulse();
        check1("reset_clears_err", proto_err, 1'b0);
        for (int k = 0; k < 8; k++) pc_push(gen(k));
        for (int i = 0; i < 32; i++) begin
            pc_push(gen(8 + i));
            host_write(8'(192 + i));
            check8("from_host_order", pc_rx_data, 8'(192 + i));
            pc_rx_ready = 1'b1;
            tick(1);
            pc_rx_ready = 1'b0;
            host_read(d0, d1, 5);
            check8("to_host_order", d0, gen(i));
        end
        for (int k = 32; k < 40; k++) begin
            host_read(d0, d1, 5);
            check8("to_host_tail", d0, gen(k));
        end
        check1("traffic_tx_empty", rx_available, 1'b1);
        check1("traffic_rx_empty", pc_rx_valid, 1'b0);
        check1("traffic_no_err", proto_err, 1'b0);

        // read with nothing queued
        rd_n = 1'b0;
        #1;
        check8("empty_read_bus", bus, 8'hFF);
        tick(3);
        rd_n = 1'b1;
        tick(5);
        check1("empty_read_err", proto_err, 1'b1);
        check1("empty_read_rxf", rx_available, 1'b1);
        pc_push(8'h77);
        host_read(d0, d1, 5);
        check8("after_empty_read", d0, 8'h77);

        // reset in the middle of a read strobe
        host_write(8'h44);
        pc_push(8'h91);
        pc_push(8'h92);
        pc_push(8'h93);
        rd_n = 1'b0;
        #1;
        check8("pre_reset_bus", bus, 8'h91);
        tick(3);
        rst_n = 1'b0;
        #1;
        check8("reset_bus_z", bus, 8'hFF);
        check1("reset_rxf", rx_available, 1'b1);
        check1("reset_rx_valid", pc_rx_valid, 1'b0);
        check1("reset_err", proto_err, 1'b0);
        check1("reset_tx_ready", pc_tx_ready, 1'b0);
        tick(2);

        // release with RD# still low: no new fall, nothing popped
        rst_n = 1'b1;
        tick(4);
        check1("release_rxf_flushed", rx_available, 1'b1);
        check1("release_no_err", proto_err, 1'b0);
        pc_push(8'h66);
        check1("release_rxf_low", rx_available, 1'b0);
        tick(3);
        check8("held_rd_bus", bus, 8'h66);
        check1("held_rd_no_err", proto_err, 1'b0);
        rd_n = 1'b1;
        tick(5);
        check1("held_rd_no_pop", rx_available, 1'b0);
        host_read(d0, d1, 5);
        check8("held_rd_byte", d0, 8'h66);
        check1("held_rd_drained", rx_available, 1'b1);

        // write strobe during an active read
        pc_push(8'h5A);
        rd_n = 1'b0;
        #1;
        d0 = bus;
        tick(3);
        wr_n = 1'b0;
        tick(1);
        wr_n = 1'b1;
        tick(3);
        check8("overlap_read_data", d0, 8'h5A);
        check1("overlap_write_dropped", pc_rx_valid, 1'b0);
        check1("overlap_err", proto_err, 1'b1);
        rd_n = 1'b1;
        tick(5);
        check1("overlap_read_popped", rx_available, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
